// File: rtl/sw_scoreboard_local.sv
// Smith-Waterman local-alignment scoreboard.
// Fills the N x M DP matrix one cell per cycle using a row buffer plus a diag
// register, stores a 2-bit traceback pointer per cell, then streams the aligned
// symbol pairs end-to-start over a ready/valid handshake.
module sw_scoreboard_local #(
  parameter int         N        = 8,
  parameter int         M        = 8,
  parameter int         SW       = 16,
  parameter int         MATCH    = 2,
  parameter int         MISMATCH = 1,
  parameter int         GAP      = 1,
  parameter logic [2:0] GAP_CODE = 3'b010
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3*N-1:0]           sequence1,
  input  logic [3*M-1:0]           sequence2,
  output logic                     busy,
  output logic [SW-1:0]            score,
  output logic [$clog2(N+1)-1:0]   end_i,
  output logic [$clog2(M+1)-1:0]   end_j,
  output logic                     score_valid,
  output logic [2:0]               seq1_out,
  output logic [2:0]               seq2_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sw_done
);

  localparam int IW = $clog2(N+1);
  localparam int JW = $clog2(M+1);
  localparam int PW = (N*M > 1) ? $clog2(N*M) : 1;

  localparam logic signed [SW+1:0] LP_MATCH    = (SW+2)'(MATCH);
  localparam logic signed [SW+1:0] LP_MISMATCH = (SW+2)'(MISMATCH);
  localparam logic signed [SW+1:0] LP_GAP      = (SW+2)'(GAP);
  localparam logic signed [SW+1:0] LP_SATMAX   = {2'b00, {SW{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_TRACE} state_t;
  typedef enum logic [1:0] {P_STOP, P_DIAG, P_UP, P_LEFT} ptr_t;

  state_t r_state, w_state_nxt;

  // Sequence symbols, index 1..N / 1..M (entry 0 is unused and held at 0).
  logic [2:0]    r_sym1 [N+1];
  logic [2:0]    r_sym2 [M+1];
  // r_row[j] holds H[i-1][j] until cell (i,j) overwrites it with H[i][j];
  // r_row[0] stays 0 as the boundary column.
  logic [SW-1:0] r_row  [M+1];
  logic [SW-1:0] r_diag;
  ptr_t          r_ptr  [N*M];

  logic [IW-1:0] r_i, r_ti, r_mi, r_end_i;
  logic [JW-1:0] r_j, r_tj, r_mj, r_end_j;
  logic [SW-1:0] r_max, r_score;
  logic          r_score_valid, r_sw_done;

  // Fill datapath signals
  logic                 w_last, w_match, w_upd;
  logic [JW-1:0]        w_jm1;
  logic signed [SW+1:0] w_s, w_u, w_l, w_hmax;
  logic [SW-1:0]        w_h, w_max_n;
  logic [IW-1:0]        w_mi_n;
  logic [JW-1:0]        w_mj_n;
  ptr_t                 w_ptr;
  logic [PW-1:0]        w_faddr;

  // Trace datapath signals
  logic [PW-1:0]        w_tidx, w_nidx;
  ptr_t                 w_tptr;
  logic [IW-1:0]        w_ni;
  logic [JW-1:0]        w_nj;
  logic                 w_tend;

  assign score       = r_score;
  assign end_i       = r_end_i;
  assign end_j       = r_end_j;
  assign score_valid = r_score_valid;
  assign sw_done     = r_sw_done;

  assign w_last  = (r_i == IW'(N)) && (r_j == JW'(M));
  assign w_jm1   = r_j - JW'(1);
  assign w_match = (r_sym1[r_i] == r_sym2[r_j]);
  assign w_faddr = PW'((int'(r_i) - 1) * M + int'(r_j) - 1);

  // Candidate scores for the current cell: diagonal, from above, from the left.
  always_comb begin
    w_s = $signed({2'b00, r_diag}) + (w_match ? LP_MATCH : -LP_MISMATCH);
    w_u = $signed({2'b00, r_row[r_j]}) - LP_GAP;
    w_l = $signed({2'b00, r_row[w_jm1]}) - LP_GAP;
  end

  // Zero-clamped maximum, saturation, and tie-broken traceback pointer.
  always_comb begin
    w_hmax = '0;
    if (w_s > w_hmax) w_hmax = w_s;
    if (w_u > w_hmax) w_hmax = w_u;
    if (w_l > w_hmax) w_hmax = w_l;
    if (w_hmax > LP_SATMAX) w_h = '1;
    else                    w_h = w_hmax[SW-1:0];
    if (w_hmax == '0)       w_ptr = P_STOP;
    else if (w_s == w_hmax) w_ptr = P_DIAG;
    else if (w_u == w_hmax) w_ptr = P_UP;
    else                    w_ptr = P_LEFT;
  end

  // Running maximum including the current cell; strict compare keeps the first occurrence.
  always_comb begin
    w_upd   = (r_state == S_FILL) && (w_h > r_max);
    w_max_n = w_upd ? w_h : r_max;
    w_mi_n  = w_upd ? r_i : r_mi;
    w_mj_n  = w_upd ? r_j : r_mj;
  end

  // Traceback step: current pointer, the next cell, and whether that cell ends the trace.
  always_comb begin
    w_tidx = PW'((int'(r_ti) - 1) * M + int'(r_tj) - 1);
    w_tptr = r_ptr[w_tidx];
    case (w_tptr)
      P_DIAG: begin w_ni = r_ti - IW'(1); w_nj = r_tj - JW'(1); end
      P_UP:   begin w_ni = r_ti - IW'(1); w_nj = r_tj;          end
      default: begin w_ni = r_ti;         w_nj = r_tj - JW'(1); end
    endcase
    w_nidx = PW'((int'(w_ni) - 1) * M + int'(w_nj) - 1);
    w_tend = (w_ni == '0) || (w_nj == '0) || (r_ptr[w_nidx] == P_STOP);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    out_valid   = 1'b0;
    seq1_out    = '0;
    seq2_out    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = (w_max_n == '0) ? S_FLUSH : S_TRACE;
      end
      S_FLUSH: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_TRACE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        seq1_out  = (w_tptr == P_LEFT) ? GAP_CODE : r_sym1[r_ti];
        seq2_out  = (w_tptr == P_UP)   ? GAP_CODE : r_sym2[r_tj];
        if (out_ready && w_tend) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: fill/trace coordinates, running max, result and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i           <= '0;
      r_j           <= '0;
      r_ti          <= '0;
      r_tj          <= '0;
      r_mi          <= '0;
      r_mj          <= '0;
      r_max         <= '0;
      r_score       <= '0;
      r_end_i       <= '0;
      r_end_j       <= '0;
      r_score_valid <= 1'b0;
      r_sw_done     <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;
      r_sw_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i   <= IW'(1);
            r_j   <= JW'(1);
            r_max <= '0;
            r_mi  <= '0;
            r_mj  <= '0;
          end
        end
        S_FILL: begin
          r_max <= w_max_n;
          r_mi  <= w_mi_n;
          r_mj  <= w_mj_n;
          if (r_j == JW'(M)) begin
            r_j <= JW'(1);
            r_i <= r_i + IW'(1);
          end else begin
            r_j <= r_j + JW'(1);
          end
          if (w_last) begin
            r_score       <= w_max_n;
            r_end_i       <= w_mi_n;
            r_end_j       <= w_mj_n;
            r_score_valid <= 1'b1;
            r_ti          <= w_mi_n;
            r_tj          <= w_mj_n;
            if (w_max_n == '0) r_sw_done <= 1'b1;
          end
        end
        S_TRACE: begin
          if (out_ready) begin
            r_ti <= w_ni;
            r_tj <= w_nj;
            if (w_tend) r_sw_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix storage: symbols and row buffer initialised on start, cells written during fill.
  // The diag register takes the old r_row[j] before it is overwritten, and restarts at 0 per row.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_sym1[0] <= '0;
          r_sym2[0] <= '0;
          for (int unsigned k = 1; k <= N; k++) r_sym1[k] <= sequence1[3*(N-k) +: 3];
          for (int unsigned k = 1; k <= M; k++) r_sym2[k] <= sequence2[3*(M-k) +: 3];
          for (int unsigned k = 0; k <= M; k++) r_row[k] <= '0;
          r_diag <= '0;
        end
      end
      S_FILL: begin
        r_row[r_j]     <= w_h;
        r_ptr[w_faddr] <= w_ptr;
        r_diag         <= (r_j == JW'(M)) ? '0 : r_row[r_j];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sw_scoreboard_local.sv
// Bench for sw_scoreboard_local: table of alignment cases on a 4x4 and a 3x5
// instance, expected pairs queued at start and popped on each handshake.
module tb_sw_scoreboard_local;

  localparam logic [2:0] A  = 3'b000;
  localparam logic [2:0] C  = 3'b001;
  localparam logic [2:0] G  = 3'b011;
  localparam logic [2:0] T  = 3'b100;
  localparam logic [2:0] GP = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b, out_ready, sel_b;
  logic [11:0] s1a, s2a;
  logic [8:0]  s1b;
  logic [14:0] s2b;

  logic        busy_a, sv_a, ov_a, done_a;
  logic [15:0] score_a;
  logic [2:0]  ei_a, ej_a, o1_a, o2_a;
  logic        busy_b, sv_b, ov_b, done_b;
  logic [15:0] score_b;
  logic [1:0]  ei_b;
  logic [2:0]  ej_b, o1_b, o2_b;

  logic        m_busy, m_sv, m_ov, m_done;
  logic [15:0] m_score;
  logic [2:0]  m_ei, m_ej, m_s1, m_s2;

  always #5 clk = ~clk;

  sw_scoreboard_local #(.N(4), .M(4)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .sequence1(s1a), .sequence2(s2a),
    .busy(busy_a), .score(score_a), .end_i(ei_a), .end_j(ej_a), .score_valid(sv_a),
    .seq1_out(o1_a), .seq2_out(o2_a), .out_valid(ov_a), .out_ready(out_ready), .sw_done(done_a)
  );

  sw_scoreboard_local #(.N(3), .M(5)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .sequence1(s1b), .sequence2(s2b),
    .busy(busy_b), .score(score_b), .end_i(ei_b), .end_j(ej_b), .score_valid(sv_b),
    .seq1_out(o1_b), .seq2_out(o2_b), .out_valid(ov_b), .out_ready(out_ready), .sw_done(done_b)
  );

  always_comb begin
    if (sel_b) begin
      m_busy = busy_b; m_sv = sv_b; m_ov = ov_b; m_done = done_b; m_score = score_b;
      m_ei = {1'b0, ei_b}; m_ej = ej_b; m_s1 = o1_b; m_s2 = o2_b;
    end else begin
      m_busy = busy_a; m_sv = sv_a; m_ov = ov_a; m_done = done_a; m_score = score_a;
      m_ei = ei_a; m_ej = ej_a; m_s1 = o1_a; m_s2 = o2_a;
    end
  end

  typedef struct {
    string          name;
    bit             use_b;
    logic [14:0]    s1;
    logic [14:0]    s2;
    int             score;
    int             ei;
    int             ej;
    int             npairs;
    logic [3:0][5:0] pairs;     // pair k in pairs[k], first emitted is [0]
    int             stall_at;   // index of the pair held back by out_ready=0
    int             stall_len;
    int             repulse;    // cycle of an extra start pulse, 0 = none
  } vec_t;

  vec_t       tbl [6];
  logic [5:0] q [$];
  int         n_err = 0;
  int         n_chk = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(input string nm, input bit ub, input logic [14:0] a, input logic [14:0] b,
                              input int sc, input int ei, input int ej, input int np,
                              input logic [23:0] pr, input int sa, input int sl, input int rp);
    vec_t v;
    v.name = nm; v.use_b = ub; v.s1 = a; v.s2 = b; v.score = sc; v.ei = ei; v.ej = ej;
    v.npairs = np; v.pairs = pr; v.stall_at = sa; v.stall_len = sl; v.repulse = rp;
    return v;
  endfunction

  task automatic set_start(input bit b);
    start_a = b & ~sel_b;
    start_b = b & sel_b;
  endtask

  task automatic run_case(input vec_t v);
    int nm, exp_done, stall_s;
    bit seen_sv, seen_done;
    logic [5:0] e;
    nm       = v.use_b ? 15 : 16;
    exp_done = (v.score == 0) ? nm + 1 : nm + 1 + v.npairs + v.stall_len;
    stall_s  = nm + 1 + v.stall_at;
    q.delete();
    for (int k = 0; k < v.npairs; k++) q.push_back(v.pairs[k]);
    sel_b = v.use_b;
    s1a = v.s1[11:0]; s2a = v.s2[11:0]; s1b = v.s1[8:0]; s2b = v.s2;
    out_ready = 1'b1;
    seen_sv = 1'b0; seen_done = 1'b0;
    set_start(1'b1);
    for (int cyc = 1; cyc <= nm + 40 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      set_start(cyc == v.repulse);
      out_ready = !(v.stall_len > 0 && cyc >= stall_s && cyc < stall_s + v.stall_len);
      if (cyc == 1) chk("busy_rise", m_busy, 1);
      if (cyc == nm) begin
        chk("busy_fill_end", m_busy, 1);
        chk("score_valid_early", m_sv, 0);
      end
      if (m_sv) begin
        chk("score_valid_cycle", cyc, nm + 1);
        chk("score", m_score, v.score);
        chk("end_i", m_ei, v.ei);
        chk("end_j", m_ej, v.ej);
        seen_sv = 1'b1;
      end
      if (m_ov) begin
        if (q.size() == 0) chk("extra_pair_valid", m_ov, 0);
        else if (out_ready) begin
          e = q.pop_front();
          chk("pair", {m_s1, m_s2}, e);
        end else chk("pair_hold", {m_s1, m_s2}, q[0]);
      end else chk("idle_pair_zero", {m_s1, m_s2}, 0);
      if (m_done) begin
        chk("done_cycle", cyc, exp_done);
        chk("done_out_valid", m_ov, 0);
        chk("done_busy", m_busy, (v.score == 0) ? 1 : 0);
        seen_done = 1'b1;
      end
    end
    chk("done_seen", seen_done, 1);
    chk("score_valid_seen", seen_sv, 1);
    chk("pairs_left", q.size(), 0);
    @(posedge clk); #1;
    chk("busy_after", m_busy, 0);
    chk("done_single", m_done, 0);
  endtask

  initial begin
    bit quiet;
    rst_n = 1'b0; sel_b = 1'b0; out_ready = 1'b0;
    s1a = '0; s2a = '0; s1b = '0; s2b = '0;
    set_start(1'b0);

    tbl[0] = mk("match4", 0, {A,C,G,T}, {A,C,G,T}, 8, 4, 4, 4, {{A,A},{C,C},{G,G},{T,T}}, 0, 0, 0);
    tbl[1] = mk("zero",   0, {A,A,A,A}, {C,C,C,C}, 0, 0, 0, 0, 24'd0, 0, 0, 0);
    tbl[2] = mk("gap",    0, {A,C,G,T}, {A,C,T,A}, 5, 4, 3, 4, {{A,A},{C,C},{G,GP},{T,T}}, 0, 0, 0);
    tbl[3] = mk("stall",  0, {A,C,G,T}, {A,C,T,A}, 5, 4, 3, 4, {{A,A},{C,C},{G,GP},{T,T}}, 1, 3, 0);
    tbl[4] = mk("repulse",0, {A,C,G,T}, {A,C,G,T}, 8, 4, 4, 4, {{A,A},{C,C},{G,G},{T,T}}, 0, 0, 5);
    tbl[5] = mk("n3m5",   1, {C,G,T},   {A,C,G,T,A}, 6, 3, 4, 3, {6'd0,{C,C},{G,G},{T,T}}, 0, 0, 0);

    #12;
    chk("rst_busy", m_busy, 0);
    chk("rst_score_valid", m_sv, 0);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_sw_done", m_done, 0);
    chk("rst_score", m_score, 0);
    chk("rst_end", {m_ei, m_ej}, 0);
    chk("rst_pair", {m_s1, m_s2}, 0);
    chk("rst_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_case(tbl[t]);

    // Reset in the middle of FILL, then a clean rerun.
    sel_b = 1'b0; s1a = {A,C,G,T}; s2a = {A,C,G,T}; out_ready = 1'b1;
    set_start(1'b1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      set_start(1'b0);
    end
    chk("busy_before_reset", m_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", m_busy, 0);
    chk("abort_score", m_score, 0);
    chk("abort_end", {m_ei, m_ej}, 0);
    chk("abort_flags", {m_sv, m_ov, m_done}, 0);
    chk("abort_pair", {m_s1, m_s2}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk); #1;
      if (m_done || m_busy || m_ov) quiet = 1'b0;
    end
    chk("abort_quiet", quiet, 1);
    run_case(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
